dynamic_branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor: an 8-entry Branch History Table of 2-bit saturating counters and an 8-entry Branch Target Buffer, both indexed by PC bits [3:1]. Fetch reads it combinationally each cycle to choose the next PC. Decode writes back the resolved outcome one stage later. The block also flags mispredictions and keeps saturating branch/mispredict counts. Its per-entry PC tag, 2-bit state and target are the exact fields the BHT/BTB dump logs, so its arrays are exposed for the monitor.

---
 rtl/dynamic_branch_predictor_pkg.sv | 40 ++++
 rtl/dynamic_branch_predictor_sat_counter_2b.sv | 25 ++
 rtl/dynamic_branch_predictor.sv | 107 ++++++++++
 tb/tb_dynamic_branch_predictor.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dynamic_branch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor and the BHT/BTB dump monitor.
// Entry field names match the monitor's log format.
package dynamic_branch_predictor_pkg;

  localparam int ENTRIES = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b10,
    STRONG_TAKEN     = 2'b11
  } state_t;

  typedef struct packed {
    logic [15:0] PC_addr;
    state_t      prediction;
    logic        valid;
  } bht_entry_t;

  typedef struct packed {
    logic [15:0] PC_addr;
    logic [15:0] target;
  } btb_entry_t;

  // One saturating step toward the resolved direction; both ends hold.
  function automatic state_t sat_step(input state_t s, input logic up);
    state_t r;
    r = s;
    case (s)
      STRONG_NOT_TAKEN: r = up ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   r = up ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
      WEAK_TAKEN:       r = up ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
      STRONG_TAKEN:     r = up ? STRONG_TAKEN   : WEAK_TAKEN;
      default:          r = STRONG_NOT_TAKEN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dynamic_branch_predictor_sat_counter_2b.sv
// 2-bit saturating up/down counter with load; one per BHT entry.
// Load (entry allocation) takes priority over a counting step.
module sat_counter_2b
  import dynamic_branch_predictor_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  state_t load_val,
  input  logic   step_en,
  input  logic   up,
  output state_t state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STRONG_NOT_TAKEN;
    end else if (load) begin
      state <= load_val;
    end else if (step_en) begin
      state <= sat_step(state, up);
    end
  end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage BHT/BTB predictor with decode-stage writeback, mispredict flag
// and saturating branch/mispredict counters.
module dynamic_branch_predictor
  import dynamic_branch_predictor_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] PC_curr,
  output logic        predicted_taken,
  output logic [15:0] predicted_target,
  input  logic        update_en,
  input  logic        id_stall,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic        IF_ID_predicted_taken,
  input  logic [15:0] IF_ID_predicted_target,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  output logic        mispredicted,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  logic [15:0]        bht_tag   [ENTRIES];
  logic [ENTRIES-1:0] bht_valid;
  state_t             bht_state [ENTRIES];
  btb_entry_t         btb       [ENTRIES];
  bht_entry_t         bht       [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             upd;
  logic             wr_hit;
  state_t           alloc_state;

  assign rd_idx = PC_curr[IDX_W:1];
  assign wr_idx = IF_ID_PC_curr[IDX_W:1];
  assign upd    = update_en & ~id_stall;
  assign wr_hit = bht_valid[wr_idx] & (bht_tag[wr_idx] == IF_ID_PC_curr);

  always_comb begin
    alloc_state = WEAK_NOT_TAKEN;
    if (actual_taken) alloc_state = WEAK_TAKEN;
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_bht_ctr
    logic sel;
    assign sel = upd & (wr_idx == IDX_W'(e));
    sat_counter_2b u_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (sel & ~wr_hit),
      .load_val (alloc_state),
      .step_en  (sel & wr_hit),
      .up       (actual_taken),
      .state    (bht_state[e])
    );
  end

  // Tags, valids and BTB; the BTB only learns from taken outcomes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bht_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        bht_tag[i] <= 16'h0000;
        btb[i]     <= '0;
      end
    end else if (upd) begin
      bht_tag[wr_idx]   <= IF_ID_PC_curr;
      bht_valid[wr_idx] <= 1'b1;
      if (actual_taken) begin
        btb[wr_idx].PC_addr <= IF_ID_PC_curr;
        btb[wr_idx].target  <= actual_target;
      end
    end
  end

  // Packed view of the BHT for the dump monitor.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      bht[i].PC_addr    = bht_tag[i];
      bht[i].prediction = bht_state[i];
      bht[i].valid      = bht_valid[i];
    end
  end

  always_comb begin
    predicted_taken  = bht_valid[rd_idx] & (bht_tag[rd_idx] == PC_curr) &
                       bht_state[rd_idx][1] & (btb[rd_idx].PC_addr == PC_curr);
    predicted_target = predicted_taken ? btb[rd_idx].target : PC_curr + 16'd2;
  end

  assign mispredicted = upd & ((IF_ID_predicted_taken != actual_taken) |
                               (actual_taken & (IF_ID_predicted_target != actual_target)));

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count     <= 16'h0000;
      mispredict_count <= 16'h0000;
    end else begin
      if (upd && branch_count != 16'hFFFF)
        branch_count <= branch_count + 16'd1;
      if (mispredicted && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Self-checking bench for dynamic_branch_predictor: vector table plus
// stall, mid-operation reset and counter saturation sequences.
module tb_dynamic_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PC_curr;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        update_en;
  logic        id_stall;
  logic [15:0] IF_ID_PC_curr;
  logic        IF_ID_predicted_taken;
  logic [15:0] IF_ID_predicted_target;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic        mispredicted;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  dynamic_branch_predictor dut (
    .clk                    (clk),
    .rst                    (rst),
    .PC_curr                (PC_curr),
    .predicted_taken        (predicted_taken),
    .predicted_target       (predicted_target),
    .update_en              (update_en),
    .id_stall               (id_stall),
    .IF_ID_PC_curr          (IF_ID_PC_curr),
    .IF_ID_predicted_taken  (IF_ID_predicted_taken),
    .IF_ID_predicted_target (IF_ID_predicted_target),
    .actual_taken           (actual_taken),
    .actual_target          (actual_target),
    .mispredicted           (mispredicted),
    .branch_count           (branch_count),
    .mispredict_count       (mispredict_count)
  );

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        ue;
    logic        st;
    logic [15:0] ipc;
    logic        ipt;
    logic [15:0] iptgt;
    logic        at;
    logic [15:0] atgt;
    logic        chk;
    logic        e_pt;
    logic [15:0] e_tgt;
    logic        e_misp;
    logic [15:0] e_bc;
    logic [15:0] e_mc;
  } vec_t;

  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [15:0] pc, logic ue, logic st, logic [15:0] ipc,
                              logic ipt, logic [15:0] iptgt, logic at, logic [15:0] atgt,
                              logic e_pt, logic [15:0] e_tgt, logic e_misp,
                              logic [15:0] e_bc, logic [15:0] e_mc);
    vec_t r;
    r.rst = 1'b0; r.pc = pc; r.ue = ue; r.st = st; r.ipc = ipc; r.ipt = ipt;
    r.iptgt = iptgt; r.at = at; r.atgt = atgt; r.chk = 1'b1; r.e_pt = e_pt;
    r.e_tgt = e_tgt; r.e_misp = e_misp; r.e_bc = e_bc; r.e_mc = e_mc;
    return r;
  endfunction

  function automatic vec_t idle(logic [15:0] pc, logic e_pt, logic [15:0] e_tgt,
                                logic [15:0] e_bc, logic [15:0] e_mc);
    return mk(pc, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, e_pt, e_tgt, 1'b0, e_bc, e_mc);
  endfunction

  task automatic check(string name, int idx, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Drive one cycle's inputs, compare combinational outputs and pre-edge counters, then clock.
  task automatic apply(vec_t v, int idx);
    vec_t e;
    rst = v.rst; PC_curr = v.pc; update_en = v.ue; id_stall = v.st;
    IF_ID_PC_curr = v.ipc; IF_ID_predicted_taken = v.ipt; IF_ID_predicted_target = v.iptgt;
    actual_taken = v.at; actual_target = v.atgt;
    sb_q.push_back(v);
    #2;
    e = sb_q.pop_front();
    if (e.chk) begin
      check("predicted_taken", idx, {15'd0, predicted_taken}, {15'd0, e.e_pt});
      check("predicted_target", idx, predicted_target, e.e_tgt);
      check("mispredicted", idx, {15'd0, mispredicted}, {15'd0, e.e_misp});
      check("branch_count", idx, branch_count, e.e_bc);
      check("mispredict_count", idx, mispredict_count, e.e_mc);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    rv = idle(16'h0010, 1'b0, 16'h0012, 16'h0, 16'h0);
    rv.rst = 1'b1; rv.chk = 1'b0;
    @(posedge clk);
    #1;
    apply(rv, -1);

    // pc, ue, st, ipc, ipt, iptgt, at, atgt | pt, tgt, misp, bc, mc (pre-edge)
    tbl.push_back(idle(16'h0010, 0, 16'h0012, 0, 0));
    tbl.push_back(mk(16'h0010, 1, 0, 16'h0010, 0, 16'h0012, 1, 16'h0040, 0, 16'h0012, 1, 0, 0));
    tbl.push_back(idle(16'h0010, 1, 16'h0040, 1, 1));
    tbl.push_back(mk(16'h0010, 1, 0, 16'h0010, 1, 16'h0040, 1, 16'h0040, 1, 16'h0040, 0, 1, 1));
    tbl.push_back(mk(16'h0010, 1, 0, 16'h0010, 1, 16'h0040, 1, 16'h0040, 1, 16'h0040, 0, 2, 1));
    tbl.push_back(mk(16'h0010, 1, 0, 16'h0010, 1, 16'h0040, 1, 16'h0040, 1, 16'h0040, 0, 3, 1));
    tbl.push_back(mk(16'h0010, 1, 0, 16'h0010, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040, 1, 4, 1));
    tbl.push_back(mk(16'h0010, 1, 0, 16'h0010, 1, 16'h0040, 0, 16'h0000, 1, 16'h0040, 1, 5, 2));
    tbl.push_back(idle(16'h0010, 0, 16'h0012, 6, 3));
    tbl.push_back(mk(16'h0010, 1, 0, 16'h0020, 0, 16'h0022, 0, 16'h0000, 0, 16'h0012, 0, 6, 3));
    tbl.push_back(idle(16'h0010, 0, 16'h0012, 7, 3));
    tbl.push_back(idle(16'h0020, 0, 16'h0022, 7, 3));
    tbl.push_back(mk(16'h0004, 1, 0, 16'h0004, 0, 16'h0006, 1, 16'h0100, 0, 16'h0006, 1, 7, 3));
    tbl.push_back(idle(16'h0004, 1, 16'h0100, 8, 4));
    tbl.push_back(idle(16'h0010, 0, 16'h0012, 8, 4));
    tbl.push_back(mk(16'h0004, 1, 0, 16'h0004, 1, 16'h0100, 1, 16'h0200, 1, 16'h0100, 1, 8, 4));
    tbl.push_back(idle(16'h0004, 1, 16'h0200, 9, 5));
    tbl.push_back(idle(16'hFFFE, 0, 16'h0000, 9, 5));
    foreach (tbl[i]) apply(tbl[i], i);

    // Stalled update held three cycles, then released once.
    for (int i = 0; i < 3; i++)
      apply(mk(16'h0004, 1, 1, 16'h0004, 1, 16'h0200, 0, 16'h0000, 1, 16'h0200, 0, 9, 5), 100 + i);
    apply(mk(16'h0004, 1, 0, 16'h0004, 1, 16'h0200, 0, 16'h0000, 1, 16'h0200, 1, 9, 5), 103);
    apply(idle(16'h0004, 1, 16'h0200, 10, 6), 104);
    apply(idle(16'h0004, 1, 16'h0200, 10, 6), 105);

    // Reset while an update is presented: reset wins.
    rv = mk(16'h0004, 1, 0, 16'h0004, 0, 16'h0006, 1, 16'h0300, 0, 16'h0, 0, 0, 0);
    rv.rst = 1'b1; rv.chk = 1'b0;
    apply(rv, 200);
    apply(idle(16'h0004, 0, 16'h0006, 0, 0), 201);
    apply(idle(16'h0010, 0, 16'h0012, 0, 0), 202);
    for (int i = 0; i < 8; i++)
      check("valid_after_reset", 210 + i, {15'd0, dut.bht[i].valid}, 16'h0000);

    // Counter saturation: 65535 mispredicted updates reach 0xFFFF, more must hold.
    rv = mk(16'h0008, 1, 0, 16'h0008, 0, 16'h000A, 1, 16'h0080, 0, 16'h0, 0, 0, 0);
    rv.chk = 1'b0;
    for (int i = 0; i < 65535; i++) apply(rv, 300);
    apply(idle(16'h0008, 1, 16'h0080, 16'hFFFF, 16'hFFFF), 301);
    apply(mk(16'h0008, 1, 0, 16'h0008, 0, 16'h000A, 1, 16'h0080, 1, 16'h0080, 1,
             16'hFFFF, 16'hFFFF), 302);
    apply(idle(16'h0008, 1, 16'h0080, 16'hFFFF, 16'hFFFF), 303);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
